shift_right_seq: RTL and testbench
==================================

# shift_right_seq

Sequential right-shift unit: shifts an N-bit operand right by 0–15 positions at one bit per clock, logical or arithmetic. Start/busy/done handshake with registered result and status flags. Right-shift companion to the combinational left shifter in the ALU datapath; used where a multi-cycle, area-lean shift is acceptable.

## Interface
- N, default 8: operand width; legal range 2..15.
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- data_in  in  N  operand; captured on the accepting edge.
- shift_count  in  4  shift amount k; captured with data_in.
- arith  in  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured with data_in.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse; result and flags valid.
- data_out  out  N  registered result; holds until the next done.
- V  out  1  out-of-range: k >= N.
- C  out  1  last bit shifted out.
- Z  out  1  result == 0.

## Operation
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE).
- IDLE or DONE with start=1: capture data_in, k, arith into a working register and down-counter.
  - k == 0: go to DONE; result = operand; C=0; V=0.
  - k >= N: go to DONE; result = 0 (logical) or all copies of operand[N-1] (arith); C=0; V=1.
  - else: go to SHIFT; counter = k.
- IDLE or DONE with start=0: go to / stay in IDLE.
- SHIFT, each edge: working >>= 1. Fill bit is working[N-1] if arith, else 0. C_work <= working[0]. Counter decrements. On the edge where the counter goes 1→0, go to DONE.
- Entering DONE: data_out, C, V, and Z (computed from the final result) all load in the same edge.
- Outside DONE: data_out and flags hold their last values.
- start while busy=1: ignored, no queuing.
- Inputs sampled only on the accepting edge; later changes to them have no effect.
- Back-to-back: start in DONE is accepted in that same cycle. The done pulse still lasts exactly one cycle.

## Timing
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, data_out=0, V=0, C=0, Z=0. Effect is immediate, mid-operation included; the in-flight operation is discarded with no done pulse.
- First rising edge with rst_n=1 may accept start.
- Latency: start sampled at edge 0 → done high in the cycle after edge k.
  - 0 < k < N: k+1 cycles.
  - k == 0 or k >= N: 1 cycle.
- busy is high for exactly k cycles (0 when k==0 or k>=N).
- Throughput: one operation per k+1 cycles with start held high.

## Configuration
- SHIFT_RIGHT_ARITH_EN defined: arith honoured as specified.
- Not defined: arith port still present but ignored; every operation is logical (zero fill; k>=N yields 0). Removes the sign-fill mux.

## Structure
- Shared package shift_pkg: state typedef (IDLE, SHIFT, DONE), shift-count width constant (4), maximum legal N constant.
- Package is reused by the left shifter's future sequential variant.
- No sub-module: a single FSM plus datapath is natural at this size.

## Test plan
- N=8, data_in=8'hB4, k=3, arith=0 → busy 3 cycles; done 4 cycles after start; data_out=8'h16, C=1, V=0, Z=0.
- Same with arith=1 (macro defined) → data_out=8'hF6, C=1. Without the macro → 8'h16.
- data_in=8'h5A, k=0 → done next cycle, busy never high, data_out=8'h5A, C=0, V=0, Z=0.
- data_in=8'hFF, k=9, arith=0 → done after 1 cycle, data_out=8'h00, V=1, Z=1, C=0. With arith=1 → 8'hFF, V=1, Z=0.
- data_in=8'h80, k=7; start asserted again during SHIFT with other data → ignored; done after 8 cycles, data_out=8'h01, C=0. A second start in the done cycle is accepted; its done follows k+1 cycles later.
- k=7 in progress; pull rst_n low after 3 SHIFT cycles → all outputs 0 asynchronously, no done pulse. After release, a new start k=1 on 8'h02 → data_out=8'h01.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter family: FSM state encoding,
// shift-count width and the legal operand-width bounds.
package shift_pkg;

   localparam int CNT_W = 4;
   localparam int N_MIN = 2;
   localparam int N_MAX = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_state_e;

   // True when the requested shift moves every operand bit out of the word.
   function automatic logic count_out_of_range(input logic [CNT_W-1:0] k,
                                               input logic [CNT_W-1:0] n);
      return (k >= n);
   endfunction

endpackage

// File: rtl/shift_right_seq_if.sv
// Start/busy/done handshake and result bus of the sequential right shifter.
interface shift_right_seq_if #(parameter int N = 8);

   logic                       start;
   logic [N-1:0]               data_in;
   logic [shift_pkg::CNT_W-1:0] shift_count;
   logic                       arith;
   logic                       busy;
   logic                       done;
   logic [N-1:0]               data_out;
   logic                       V;
   logic                       C;
   logic                       Z;

   modport master (
      output start, data_in, shift_count, arith,
      input  busy, done, data_out, V, C, Z
   );

   modport slave (
      input  start, data_in, shift_count, arith,
      output busy, done, data_out, V, C, Z
   );

endinterface

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter, one bit position per clock, logical or arithmetic.
// Sign fill is built only when SHIFT_RIGHT_ARITH_EN is defined; otherwise arith is ignored.
module shift_right_seq
   import shift_pkg::*;
#(
   parameter int N = 8
) (
   input logic              clk,
   input logic              rst_n,
   shift_right_seq_if.slave bus
);

   localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   shift_state_e     state_q, state_d;
   logic [N-1:0]     work_q, work_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             arith_q, arith_d;
   logic [N-1:0]     data_out_q, data_out_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             z_q, z_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             arith_in_s;
   logic             fill_s;
   logic [N-1:0]     shifted_s;
   logic [N-1:0]     sat_s;

`ifdef SHIFT_RIGHT_ARITH_EN
   assign arith_in_s = bus.arith;
`else
   logic unused_arith_s;
   assign unused_arith_s = bus.arith;
   assign arith_in_s     = 1'b0;
`endif

   // Next-state, working register and result/flag computation.
   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      arith_d    = arith_q;
      data_out_d = data_out_q;
      c_d        = c_q;
      v_d        = v_q;
      z_d        = z_q;
      fill_s     = arith_q & work_q[N-1];
      shifted_s  = {fill_s, work_q[N-1:1]};
      sat_s      = {N{arith_in_s & bus.data_in[N-1]}};

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               work_d  = bus.data_in;
               cnt_d   = bus.shift_count;
               arith_d = arith_in_s;
               if (bus.shift_count == {CNT_W{1'b0}}) begin
                  state_d    = DONE;
                  data_out_d = bus.data_in;
                  c_d        = 1'b0;
                  v_d        = 1'b0;
                  z_d        = (bus.data_in == {N{1'b0}});
               end else if (count_out_of_range(bus.shift_count, N_CNT)) begin
                  state_d    = DONE;
                  data_out_d = sat_s;
                  c_d        = 1'b0;
                  v_d        = 1'b1;
                  z_d        = (sat_s == {N{1'b0}});
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            work_d = shifted_s;
            cnt_d  = cnt_q - CNT_ONE;
            // The final shift's carry and result are published on the same edge.
            if (cnt_q == CNT_ONE) begin
               state_d    = DONE;
               data_out_d = shifted_s;
               c_d        = work_q[0];
               v_d        = 1'b0;
               z_d        = (shifted_s == {N{1'b0}});
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         work_q     <= {N{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         arith_q    <= 1'b0;
         data_out_q <= {N{1'b0}};
         c_q        <= 1'b0;
         v_q        <= 1'b0;
         z_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         arith_q    <= arith_d;
         data_out_q <= data_out_d;
         c_q        <= c_d;
         v_q        <= v_d;
         z_q        <= z_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.data_out = data_out_q;
   assign bus.C        = c_q;
   assign bus.V        = v_q;
   assign bus.Z        = z_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq (N=8): directed vectors push expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_shift_right_seq;
   import shift_pkg::*;

   localparam int N = 8;
`ifdef SHIFT_RIGHT_ARITH_EN
   localparam bit ARITH = 1'b1;
`else
   localparam bit ARITH = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic       c;
      logic       v;
      logic       z;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   shift_right_seq_if #(.N(N)) bus();

   shift_right_seq #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_data", 32'(bus.data_out), 32'(e.d));
            chk("result_C", 32'(bus.C), 32'(e.c));
            chk("result_V", 32'(bus.V), 32'(e.v));
            chk("result_Z", 32'(bus.Z), 32'(e.z));
         end
      end
   end

   task automatic drive(input logic [7:0] d, input logic [3:0] k, input logic a);
      bus.data_in     = d;
      bus.shift_count = k;
      bus.arith       = a;
      bus.start       = 1'b1;
   endtask

   task automatic wait_done(input string name, input int acc, input int edges, output int busy_n);
      busy_n = 0;
      while (!bus.done && (cyc - acc) < 40) begin
         if (bus.busy) busy_n++;
         @(posedge clk); #1;
      end
      chk({name, "_latency"}, 32'(cyc - acc), 32'(edges));
   endtask

   task automatic run(input string name, input logic [7:0] d, input logic [3:0] k, input logic a,
                      input logic [7:0] ed, input logic ec, input logic ev, input logic ez,
                      input int edges);
      int acc;
      int bn;
      exp_t e;
      e = '{d: ed, c: ec, v: ev, z: ez};
      sb.push_back(e);
      @(negedge clk);
      drive(d, k, a);
      @(posedge clk); #1;
      acc = cyc;
      bus.start = 1'b0;
      wait_done(name, acc, edges, bn);
      chk({name, "_busy_cycles"}, 32'(bn), 32'(edges));
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int acc;
      int bn;
      exp_t e;
      bus.start       = 1'b0;
      bus.data_in     = 8'h00;
      bus.shift_count = 4'd0;
      bus.arith       = 1'b0;

      #2;
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_data", 32'(bus.data_out), 32'd0);
      chk("reset_flags", 32'({bus.V, bus.C, bus.Z}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run("lsr_b4_3", 8'hB4, 4'd3, 1'b0, 8'h16, 1'b1, 1'b0, 1'b0, 3);
      run("asr_b4_3", 8'hB4, 4'd3, 1'b1, ARITH ? 8'hF6 : 8'h16, 1'b1, 1'b0, 1'b0, 3);
      run("k0_5a", 8'h5A, 4'd0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 0);
      run("lsr_ff_9", 8'hFF, 4'd9, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0);
      run("asr_ff_9", 8'hFF, 4'd9, 1'b1, ARITH ? 8'hFF : 8'h00, 1'b0, 1'b1, !ARITH, 0);
      run("asr_81_8", 8'h81, 4'd8, 1'b1, ARITH ? 8'hFF : 8'h00, 1'b0, 1'b1, !ARITH, 0);
      run("asr_81_7", 8'h81, 4'd7, 1'b1, ARITH ? 8'hFF : 8'h01, 1'b0, 1'b0, 1'b0, 7);

      // Start held during SHIFT with other operands must be ignored.
      e = '{d: 8'h01, c: 1'b0, v: 1'b0, z: 1'b0};
      sb.push_back(e);
      @(negedge clk);
      drive(8'h80, 4'd7, 1'b0);
      @(posedge clk); #1;
      acc = cyc;
      drive(8'hFF, 4'd1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done("ignore_80_7", acc, 7, bn);

      // Back-to-back: start raised in the done cycle is accepted there.
      e = '{d: 8'h10, c: 1'b1, v: 1'b0, z: 1'b0};
      sb.push_back(e);
      drive(8'h43, 4'd2, 1'b0);
      @(posedge clk); #1;
      acc = cyc;
      bus.start = 1'b0;
      chk("b2b_done_one_cycle", 32'(bus.done), 32'd0);
      chk("b2b_busy", 32'(bus.busy), 32'd1);
      wait_done("b2b_43_2", acc, 2, bn);
      chk("b2b_busy_cycles", 32'(bn), 32'd2);
      @(posedge clk); #1;

      // Asynchronous reset mid-operation discards it with no done pulse.
      @(negedge clk);
      drive(8'h80, 4'd7, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_data", 32'(bus.data_out), 32'd0);
      chk("arst_flags", 32'({bus.V, bus.C, bus.Z}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("arst_no_done", 32'(bus.done), 32'd0);

      run("after_rst_02_1", 8'h02, 4'd1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1);

      repeat (2) @(posedge clk);
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
